// File: rtl/see_drv_pkg.sv
// Shared definitions for the SEE cone stimulus driver: sweep FSM states,
// settle-counter width and maximal-length LFSR tap masks.
package see_drv_pkg;

    localparam int SETTLE_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    // Fibonacci tap masks for a shift-left LFSR whose feedback bit is the
    // parity of (state & mask); bit i of the mask is tap i+1.
    function automatic logic [7:0] lfsr_taps(input int n);
        logic [7:0] taps;
        case (n)
            3:       taps = 8'b0000_0110;
            4:       taps = 8'b0000_1100;
            5:       taps = 8'b0001_0100;
            6:       taps = 8'b0011_0000;
            7:       taps = 8'b0110_0000;
            default: taps = 8'b1011_1000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/see_vec_gen.sv
// Cone input vector generator. Binary up-count by default; with
// SEE_DRV_LFSR_EN defined it emits 0 followed by the 2^N_IN-1 states of a
// maximal-length LFSR seeded with 1.
module see_vec_gen
    import see_drv_pkg::*;
#(
    parameter int N_IN = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            advance,
    output logic [N_IN-1:0] vec,
    output logic            last
);

    logic [N_IN-1:0] vec_q;
    logic [N_IN-1:0] vec_d;
    logic [N_IN-1:0] vec_next;

`ifdef SEE_DRV_LFSR_EN
    localparam logic [7:0]      TAPS8 = lfsr_taps(N_IN);
    localparam logic [N_IN-1:0] TAPS  = TAPS8[N_IN-1:0];
    localparam logic [N_IN-1:0] SEED  = {{(N_IN-1){1'b0}}, 1'b1};

    logic [N_IN-1:0] step;

    // LFSR successor; the zero vector is outside the cycle, so it jumps to the seed
    always_comb begin
        step     = {vec_q[N_IN-2:0], ^(vec_q & TAPS)};
        vec_next = (vec_q == '0) ? SEED : step;
        last     = (vec_q != '0) && (step == SEED);
    end
`else
    localparam logic [N_IN-1:0] ONE = {{(N_IN-1){1'b0}}, 1'b1};

    // Binary order; the all-ones vector ends the sweep
    always_comb begin
        vec_next = vec_q + ONE;
        last     = &vec_q;
    end
`endif

    // Load takes priority so a new sweep always restarts at zero
    always_comb begin
        vec_d = vec_q;
        if (load) begin
            vec_d = '0;
        end else if (advance) begin
            vec_d = vec_next;
        end
    end

    // Vector register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q <= '0;
        end else begin
            vec_q <= vec_d;
        end
    end

    assign vec = vec_q;

endmodule

// File: rtl/see_cone_stim_driver.sv
// Stimulus/compare engine for an extracted SEE logic cone: sweeps every
// input vector, compares golden vs fault-injected outputs, counts mismatches.
// Optional build macro: SEE_DRV_LFSR_EN (LFSR vector order instead of binary).
//
// state     | meaning
// ST_IDLE   | waiting for start; outputs hold last sweep results
// ST_APPLY  | vector driven, inject raised, settle counter loaded
// ST_WAIT   | settle countdown, inject held
// ST_SAMPLE | compare golden/faulty, advance or finish
// ST_FINISH | inject/busy low, done set
module see_cone_stim_driver
    import see_drv_pkg::*;
#(
    parameter int N_IN   = 6,
    parameter int CNT_W  = 16,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N_IN-1:0]  vec,
    output logic             inject,
    input  logic             golden_q,
    input  logic             faulty_q,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic [N_IN-1:0]  first_err_vec,
    output logic             first_err_valid
);

    localparam logic [SETTLE_W-1:0] WAIT_LOAD = SETTLE_W'(SETTLE - 1);
    localparam logic [SETTLE_W-1:0] WAIT_ONE  = {{(SETTLE_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [SETTLE_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [N_IN-1:0]   first_q, first_d;
    logic              fvalid_q, fvalid_d;
    logic              done_q, done_d;
    logic              gen_load, gen_advance, gen_last;

    assign gen_load    = (state_q == ST_IDLE) && start;
    assign gen_advance = (state_q == ST_SAMPLE) && !gen_last;

    see_vec_gen #(.N_IN(N_IN)) u_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (gen_load),
        .advance (gen_advance),
        .vec     (vec),
        .last    (gen_last)
    );

    // Sweep sequencing, mismatch counting and first-failure capture
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        err_d    = err_q;
        first_d  = first_q;
        fvalid_d = fvalid_q;
        done_d   = done_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_APPLY;
                    err_d    = '0;
                    fvalid_d = 1'b0;
                    done_d   = 1'b0;
                end
            end
            ST_APPLY: begin
                wait_d  = WAIT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    wait_d = wait_q - WAIT_ONE;
                end
            end
            ST_SAMPLE: begin
                if (golden_q != faulty_q) begin
                    if (err_q != {CNT_W{1'b1}}) begin
                        err_d = err_q + CNT_ONE;
                    end
                    if (!fvalid_q) begin
                        first_d  = vec;
                        fvalid_d = 1'b1;
                    end
                end
                if (gen_last) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_APPLY;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wait_q   <= '0;
            err_q    <= '0;
            first_q  <= '0;
            fvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            err_q    <= err_d;
            first_q  <= first_d;
            fvalid_q <= fvalid_d;
            done_q   <= done_d;
        end
    end

    // inject covers sampling too, so the compare sees the upset cone
    assign busy            = (state_q == ST_APPLY) || (state_q == ST_WAIT) ||
                             (state_q == ST_SAMPLE);
    assign inject          = busy;
    assign done            = done_q;
    assign err_count       = err_q;
    assign first_err_vec   = first_q;
    assign first_err_valid = fvalid_q;

endmodule

// File: tb/tb_see_cone_stim_driver.sv
// Self-checking bench for see_cone_stim_driver (binary or LFSR order).
module tb_see_cone_stim_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_a, start_b;
    logic [5:0]  vec_a;
    logic        inject_a, golden_a, faulty_a, busy_a, done_a, fval_a;
    logic [15:0] err_a;
    logic [5:0]  fev_a;
    logic [3:0]  vec_b;
    logic        inject_b, golden_b, faulty_b, busy_b, done_b, fval_b;
    logic [3:0]  err_b;
    logic [3:0]  fev_b;

    logic [63:0] fault_mask;
    logic [5:0]  gmask;

    assign golden_a = ^(vec_a & gmask);
    assign faulty_a = golden_a ^ fault_mask[vec_a];
    assign golden_b = vec_b[0];
    assign faulty_b = ~golden_b;

    see_cone_stim_driver #(.N_IN(6), .CNT_W(16), .SETTLE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .vec(vec_a), .inject(inject_a),
        .golden_q(golden_a), .faulty_q(faulty_a), .busy(busy_a), .done(done_a),
        .err_count(err_a), .first_err_vec(fev_a), .first_err_valid(fval_a)
    );

    see_cone_stim_driver #(.N_IN(4), .CNT_W(4), .SETTLE(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .vec(vec_b), .inject(inject_b),
        .golden_q(golden_b), .faulty_q(faulty_b), .busy(busy_b), .done(done_b),
        .err_count(err_b), .first_err_vec(fev_b), .first_err_valid(fval_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int ord[64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected sweep order: plain count, or 0 then the x^6+x^5+1 sequence from 1
    task automatic build_order();
        int s;
`ifdef SEE_DRV_LFSR_EN
        ord[0] = 0;
        s = 1;
        for (int k = 1; k < 64; k++) begin
            ord[k] = s;
            s = ((s << 1) & 63) | (((s >> 5) ^ (s >> 4)) & 1);
        end
`else
        for (int k = 0; k < 64; k++) ord[k] = k;
`endif
    endtask

    // Reference result for a fault set: count, first faulty vector in sweep order
    task automatic ref_model(input logic [63:0] mask, output int cnt, output int first,
                             output bit valid);
        cnt = 0; first = 0; valid = 0;
        for (int k = 0; k < 64; k++) begin
            if (mask[ord[k]]) begin
                if (!valid) begin first = ord[k]; valid = 1; end
                cnt++;
            end
        end
        if (cnt > 65535) cnt = 65535;
    endtask

    task automatic sweep_a(input string tag, input bit spam, input logic [63:0] mask,
                           input int exp_err, input int exp_first, input bit exp_valid);
        int cyc = 0;
        int inj_bad = 0;
        int ord_bad = 0;
        int distinct = 0;
        int seen[64];
        int q[$];
        for (int k = 0; k < 64; k++) seen[k] = 0;
        fault_mask = mask;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        check({tag, " done_clear"}, done_a, 0);
        while (busy_a && cyc < 1000) begin
            if (q.size() == 0 || q[q.size()-1] != int'(vec_a)) q.push_back(int'(vec_a));
            if (!inject_a) inj_bad++;
            cyc++;
            start_a = spam && (cyc % 5 == 2);
            @(negedge clk);
        end
        start_a = 1'b0;
        check({tag, " busy_cycles"}, cyc, 192);
        check({tag, " done"}, done_a, 1);
        check({tag, " inject_low"}, inject_a, 0);
        check({tag, " inject_busy"}, inj_bad, 0);
        check({tag, " err_count"}, err_a, exp_err);
        check({tag, " first_valid"}, fval_a, exp_valid);
        if (exp_valid) check({tag, " first_vec"}, fev_a, exp_first);
        foreach (q[k]) begin
            if (k < 64 && q[k] != ord[k]) ord_bad++;
            if (seen[q[k] & 63] == 0) distinct++;
            seen[q[k] & 63]++;
        end
        check({tag, " nvec"}, q.size(), 64);
        check({tag, " distinct"}, distinct, 64);
        check({tag, " order"}, ord_bad, 0);
        check({tag, " vec_hold"}, vec_a, ord[63]);
        @(negedge clk);
        check({tag, " done_sticky"}, done_a, 1);
    endtask

    typedef struct {
        string       name;
        logic [63:0] mask;
        bit          spam;
        int          exp_err;
        int          exp_first;
        bit          exp_valid;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int e_cnt, e_first, cyc;
        bit e_valid;
        logic [63:0] m;

        build_order();
        tbl[0] = '{"clean",      64'd0,            1'b0, 0,  0,  1'b0};
        tbl[1] = '{"one_2a",     64'd1 << 6'h2A,   1'b0, 1,  42, 1'b1};
        tbl[2] = '{"one_zero",   64'd1,            1'b0, 1,  0,  1'b1};
        tbl[3] = '{"one_last",   64'd1 << ord[63], 1'b0, 1,  ord[63], 1'b1};
        tbl[4] = '{"all_inv",    {64{1'b1}},       1'b0, 64, 0,  1'b1};
        tbl[5] = '{"start_spam", 64'd1 << 6'h2A,   1'b1, 1,  42, 1'b1};

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        fault_mask = '0; gmask = 6'h15;
        repeat (3) @(negedge clk);
        check("rst vec", vec_a, 0);
        check("rst inject", inject_a, 0);
        check("rst busy", busy_a, 0);
        check("rst done", done_a, 0);
        check("rst err", err_a, 0);
        check("rst fev", fev_a, 0);
        check("rst fval", fval_a, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            sweep_a(tbl[i].name, tbl[i].spam, tbl[i].mask,
                    tbl[i].exp_err, tbl[i].exp_first, tbl[i].exp_valid);
        end

        for (int i = 0; i < 6; i++) begin
            m = {$urandom, $urandom};
            if (i < 3) m = m & {$urandom, $urandom} & {$urandom, $urandom};
            gmask = 6'($urandom);
            ref_model(m, e_cnt, e_first, e_valid);
            sweep_a($sformatf("rand%0d", i), 1'b0, m, e_cnt, e_first, e_valid);
        end

        // Abort mid-sweep with an asynchronous reset
        fault_mask = 64'd1 << 6'h05;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", busy_a, 0);
        check("abort inject", inject_a, 0);
        check("abort done", done_a, 0);
        check("abort vec", vec_a, 0);
        check("abort err", err_a, 0);
        check("abort fev", fev_a, 0);
        check("abort fval", fval_a, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sweep_a("post_abort", 1'b0, 64'd1 << 6'h05, 1, 5, 1'b1);

        // Narrow counter saturates; longer settle stretches each vector
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        cyc = 0;
        while (busy_b && cyc < 500) begin
            cyc++;
            @(negedge clk);
        end
        check("sat busy_cycles", cyc, 80);
        check("sat done", done_b, 1);
        check("sat err", err_b, 15);
        check("sat fev", fev_b, 0);
        check("sat fval", fval_b, 1);
        check("sat inject", inject_b, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/see_cone_stim_driver.md
Name: see_cone_stim_driver

Overview:
- Sequential stimulus/compare engine on the driving end of an extracted SEE logic cone.
- Applies every input vector of an N_IN-input cone (such as a 6-input cone) to a golden copy and a fault-injected copy of that cone.
- Waits for combinational settle, samples both outputs and counts mismatches.
- Reports the first failing vector and a done flag for the error-analysis harness.

Parameters:
- N_IN, 6, cone input count / vector width (legal range 3..8).
- CNT_W, 16, width of the mismatch counter.
- SETTLE, 1, wait cycles between vector application and sampling (legal range 1..15).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse, begins a sweep when idle.
- vec  out  N_IN  vector driven to the cone inputs of both copies.
- inject  out  1  high while a vector is applied; fault injector flips its target net only while inject=1.
- golden_q  in  1  golden cone output.
- faulty_q  in  1  faulty cone output.
- busy  out  1  sweep in progress.
- done  out  1  sticky; set at sweep end, cleared by next accepted start.
- err_count  out  CNT_W  number of mismatching vectors, saturating.
- first_err_vec  out  N_IN  vector of the first mismatch.
- first_err_valid  out  1  first_err_vec holds a real value.

Behaviour:
- Reset values: vec=0, inject=0, busy=0, done=0, err_count=0, first_err_vec=0, first_err_valid=0, FSM=IDLE.
- Reset is asynchronous and active-low. Assertion mid-sweep aborts immediately to the reset values; no partial done.
- FSM states: IDLE, APPLY, WAIT, SAMPLE, FINISH.
- IDLE:
  - start=1 moves to APPLY.
  - On that transition: clear err_count, first_err_valid and done; load vector generator with its first vector; busy=1.
  - start is ignored in every state other than IDLE.
- APPLY (1 cycle):
  - vec holds the current vector; inject=1.
  - Load wait counter with SETTLE-1; go to WAIT.
- WAIT:
  - Decrement the counter; at 0 go to SAMPLE.
  - inject stays 1.
- SAMPLE (1 cycle):
  - Compare golden_q and faulty_q. On mismatch, increment err_count, saturating at 2^CNT_W-1 (holds, no wrap).
  - On the first mismatch of the sweep, capture first_err_vec=vec and set first_err_valid=1. Later mismatches do not overwrite it.
  - If the current vector is the last, go to FINISH. Otherwise advance the generator and go to APPLY.
- FINISH (1 cycle):
  - inject=0, busy=0, done=1; go to IDLE.
  - vec holds the last vector until the next start.
- Cycles per vector: SETTLE+2. Sweep length from start to done high: 2^N_IN*(SETTLE+2)+1 cycles.
- Default order: binary count 0 .. 2^N_IN-1; the last vector is all-ones.
- inject is low in IDLE and FINISH, so the fault injector never upsets the cone between sweeps.

Optional Feature:
- Macro: SEE_DRV_LFSR_EN.
- Defined:
  - The vector generator is a maximal-length Fibonacci LFSR, seeded with 1, using tap masks from the package.
  - The all-zero vector is applied first, then the 2^N_IN-1 LFSR states.
  - The last vector is the state preceding the seed.
  - Vector count and timing are identical to the undefined case; only the order changes.
- Undefined: binary up-counter order.

Decomposition:
- Package see_drv_pkg holds:
  - state enum (IDLE, APPLY, WAIT, SAMPLE, FINISH);
  - LFSR tap-mask lookup function for N_IN 3..8;
  - constant SETTLE_W=4.
- Sub-module see_vec_gen:
  - inputs load, advance;
  - outputs vec, last;
  - contains the counter/LFSR selection under SEE_DRV_LFSR_EN.

Test Plan:
- Golden and faulty tied equal, N_IN=6, SETTLE=1, start pulse → busy 192 cycles; done high at cycle 193; err_count=0; first_err_valid=0; vecs 0..63 each seen once.
- faulty_q = golden_q XOR (vec==6'h2A), binary order → err_count=1, first_err_vec=6'h2A, first_err_valid=1.
- faulty_q inverted for all vectors, CNT_W=4 → err_count saturates at 15 (no wrap); first_err_vec=0.
- rst_n low at cycle 50 of a sweep → all outputs return to reset values at once. A new start after release gives a full 192-cycle sweep with fresh counts.
- start pulses during busy → ignored; sweep length and counts unchanged. A start in IDLE after done → done clears the next cycle.
- SEE_DRV_LFSR_EN defined, N_IN=6 → 64 distinct vectors, first 0, second 1; mismatch on one vector gives err_count=1 with that vector captured.
